sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Draws one rectangular sprite or erase box into the 160x120 frame buffer per request.
//  Sits between the game-flow datapath (upstream, issues draw requests) and the VGA adapter
//  (downstream, consumes x/y/colour/plot). Sprite pixels come from an external synchronous ROM.
//  Output rate is one pixel per clock.
// PARAMETERS
//  SPRITE_W      8        sprite width in pixels (power of 2)
//  SPRITE_H      8        sprite height in pixels (power of 2)
//  NUM_SPRITES   4        number of sprites stored in the ROM (power of 2)
//  COLOUR_W      9        colour width, 3 bits per channel
//  SCREEN_W      160      visible width; x >= SCREEN_W is clipped
//  SCREEN_H      120      visible height; y >= SCREEN_H is clipped
//  TRANSPARENT   9'h1FF   colour key that is not plotted (only when TRANSPARENCY_EN is defined)
// PORTS
//  clk         in   1    system clock (CLOCK_50)
//  reset       in   1    asynchronous, active-high reset
//  req_valid   in   1    draw request present
//  req_ready   out  1    blitter idle and able to accept a request
//  req_x       in   8    top-left x of the sprite
//  req_y       in   7    top-left y of the sprite
//  req_sprite  in   log2(NUM_SPRITES)  sprite index
//  req_erase   in   1    1 = paint an opaque box in req_colour; 0 = paint the ROM sprite
//  req_colour  in   COLOUR_W  fill colour used in erase mode
//  rom_addr    out  log2(NUM_SPRITES*SPRITE_W*SPRITE_H)  address = {sprite, row, col}
//  rom_data    in   COLOUR_W  ROM data, valid 1 cycle after rom_addr
//  x           out  8    pixel x to the VGA adapter
//  y           out  7    pixel y to the VGA adapter
//  colour      out  COLOUR_W  pixel colour
//  plot        out  1    write enable to the VGA adapter
//  done        out  1    one-cycle pulse when the final pixel of a request has been emitted
// BEHAVIOUR
//  - Reset (async): state=IDLE; req_ready, plot, done = 0; x, y, colour, rom_addr = 0.
//    req_ready rises at the first clock edge after reset is released.
//  - A request is accepted on an edge where req_valid && req_ready. The blitter captures
//    req_* and drops req_ready at the same edge. req_* are ignored while busy.
//  - FSM: IDLE -> (accept) DRAW -> (last address issued) FLUSH -> (pipe empty) DONE -> IDLE.
//    DONE lasts one cycle: done=1 and req_ready returns to 1 at the end of that cycle.
//  - In DRAW, the column counter cx (0..SPRITE_W-1) increments every cycle. When cx wraps,
//    the row counter cy increments. The state exits after (cx,cy)=(W-1,H-1).
//  - Pipeline: the address for pixel k is driven in cycle k+1 after acceptance. The outputs
//    x/y/colour/plot are registered and appear 2 cycles after their address.
//    The first plot occurs 3 cycles after acceptance. done fires in the cycle after the last
//    pixel slot. Accept to done = W*H+3 cycles (67 for 8x8).
//  - Output pixel: x=req_x+cx, y=req_y+cy, computed 1 bit wider. plot=0 whenever the sum is
//    >= SCREEN_W or >= SCREEN_H. x/y never wrap onto the opposite screen edge.
//  - Erase mode: colour=req_colour for every pixel. The ROM is still addressed, but its data
//    is ignored. Erase mode is never transparent.
//  - The ROM is addressed only in DRAW. Outside DRAW, rom_addr holds its last value.
//  - Back-to-back operation: a request may be accepted the cycle after done. There are no
//    idle plot gaps inside a request.
//  - When plot=0, x/y/colour still carry the current pipeline values (don't-care downstream).
// CONFIGURATION
//  TRANSPARENCY_EN defined:
//    - In draw mode, a pixel whose rom_data == TRANSPARENT has plot=0. The slot still
//      consumes its cycle, so timing is unchanged.
//  TRANSPARENCY_EN undefined:
//    - Every in-bounds pixel is plotted, including TRANSPARENT.
// STRUCTURE
//  - Package sprite_pkg holds SCREEN_W/H, SPRITE_W/H, COLOUR_W, the TRANSPARENT key and
//    the FSM state encoding (IDLE, DRAW, FLUSH, DONE). These are shared with the game-flow
//    datapath.
//  - One sub-module, sprite_addr_gen: the cx/cy counters, the last-pixel flag and rom_addr
//    generation.
//  - The FSM, pipeline registers, clipping and colour selection stay in the top.
// TESTING
//  1 Reset: assert reset mid-DRAW -> plot=0, done=0, req_ready=0 immediately. req_ready=1
//    one edge after release. No further plots occur.
//  2 Basic draw: req (x=10,y=20,sprite=1,erase=0), ROM filled with distinct values ->
//    64 plots at (10..17, 20..27) in row-major order. Each colour equals ROM[64+row*8+col].
//    First plot is 3 cycles after accept; done is at cycle 67.
//  3 Clip: req (x=156,y=116) -> only 16 plots, at x 156..159 and y 116..119. No x/y wrap.
//    done timing is unchanged.
//  4 Erase: req (x=0,y=0,erase=1,colour=9'h049) with ROM = 9'h1FF -> 64 plots, all 9'h049,
//    in both macro configurations.
//  5 Transparency: ROM sprite 0 is half 9'h1FF. With TRANSPARENCY_EN -> 32 plots.
//    Without it -> 64 plots. Both give done at cycle 67.
//  6 Handshake: req_valid held high for two requests -> second accepted the cycle after done.
//    req_x changed while busy has no effect on the first request.

Source files
------------

// File: rtl/sprite_pkg.sv
// ============================================================================
// Module  : sprite_pkg
// Brief   : Shared geometry, colour and FSM encoding for the sprite blitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int SPRITE_W    = 8;
  localparam int SPRITE_H    = 8;
  localparam int NUM_SPRITES = 4;
  localparam int COLOUR_W    = 9;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = $clog2(SPRITE_H);
  localparam int SPR_W  = $clog2(NUM_SPRITES);
  localparam int ADDR_W = SPR_W + ROW_W + COL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAW  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic           valid;
    logic           inb;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_t;

endpackage

`default_nettype wire

// File: rtl/sprite_blitter_if.sv
// ============================================================================
// Module  : sprite_blitter_if
// Brief   : Request, ROM and VGA-side signals of the sprite blitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_blitter_if;
  import sprite_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [SPR_W-1:0]    req_sprite;
  logic                req_erase;
  logic [COLOUR_W-1:0] req_colour;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done;

  modport master (
    input  req_valid, req_x, req_y, req_sprite, req_erase, req_colour, rom_data,
    output req_ready, rom_addr, x, y, colour, plot, done
  );

  modport slave (
    output req_valid, req_x, req_y, req_sprite, req_erase, req_colour, rom_data,
    input  req_ready, rom_addr, x, y, colour, plot, done
  );

endinterface

`default_nettype wire

// File: rtl/sprite_addr_gen.sv
// ============================================================================
// Module  : sprite_addr_gen
// Brief   : Column/row counters, last-pixel flag and sprite ROM address.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic [SPR_W-1:0]  sprite,
  output logic [COL_W-1:0]  cx,
  output logic [ROW_W-1:0]  cy,
  output logic              last,
  output logic [ADDR_W-1:0] rom_addr
);

  logic [COL_W-1:0]  r_cx;
  logic [ROW_W-1:0]  r_cy;
  logic [ADDR_W-1:0] r_rom_addr;

  // Address and counters move together; the address register holds outside DRAW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_rom_addr <= '0;
    end else if (start) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (advance) begin
      r_rom_addr <= {sprite, r_cy, r_cx};
      r_cx       <= r_cx + COL_W'(1);
      if (&r_cx) begin
        r_cy <= r_cy + ROW_W'(1);
      end
    end
  end

  assign cx       = r_cx;
  assign cy       = r_cy;
  assign last     = (&r_cx) && (&r_cy);
  assign rom_addr = r_rom_addr;

endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
// Module  : sprite_blitter
// Brief   : Draws one sprite or erase box per request, one pixel per clock.
//           Optional macro TRANSPARENCY_EN suppresses plotting of the colour key.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter
  import sprite_pkg::*;
(
  input  logic clk,
  input  logic reset,
  sprite_blitter_if.master bus
);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                r_ready;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [SPR_W-1:0]    r_sprite;
  logic                r_erase;
  logic [COLOUR_W-1:0] r_fill;
  pix_t                r_s1;
  pix_t                r_s2;
  logic [X_W-1:0]      r_px;
  logic [Y_W-1:0]      r_py;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;

  logic                w_accept;
  logic                w_draw;
  logic                w_last;
  logic                w_transp;
  logic [COL_W-1:0]    w_cx;
  logic [ROW_W-1:0]    w_cy;
  logic [ADDR_W-1:0]   w_rom_addr;
  logic [X_W:0]        w_x_sum;
  logic [Y_W:0]        w_y_sum;

  assign w_accept = bus.req_valid && r_ready;
  assign w_draw   = (r_state == ST_DRAW);

  sprite_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (w_accept),
    .advance  (w_draw),
    .sprite   (r_sprite),
    .cx       (w_cx),
    .cy       (w_cy),
    .last     (w_last),
    .rom_addr (w_rom_addr)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_DRAW;
      ST_DRAW:  if (w_last) w_next = ST_FLUSH;
      ST_FLUSH: if (!r_s1.valid && !r_s2.valid) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_sprite <= '0;
      r_erase  <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_x      <= bus.req_x;
        r_y      <= bus.req_y;
        r_sprite <= bus.req_sprite;
        r_erase  <= bus.req_erase;
        r_fill   <= bus.req_colour;
      end
    end
  end

  // One extra bit so off-screen pixels are clipped rather than wrapped.
  assign w_x_sum = {1'b0, r_x} + (X_W+1)'(w_cx);
  assign w_y_sum = {1'b0, r_y} + (Y_W+1)'(w_cy);

`ifdef TRANSPARENCY_EN
  assign w_transp = !r_erase && (bus.rom_data == TRANSPARENT);
`else
  assign w_transp = 1'b0;
`endif

  // s1 aligns with the ROM address, s2 with ROM data, then the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_s1     <= '{valid: w_draw,
                    inb:   (w_x_sum < (X_W+1)'(SCREEN_W)) && (w_y_sum < (Y_W+1)'(SCREEN_H)),
                    x:     w_x_sum[X_W-1:0],
                    y:     w_y_sum[Y_W-1:0]};
      r_s2     <= r_s1;
      r_px     <= r_s2.x;
      r_py     <= r_s2.y;
      r_colour <= r_erase ? r_fill : bus.rom_data;
      r_plot   <= r_s2.valid && r_s2.inb && !w_transp;
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rom_addr  = w_rom_addr;
  assign bus.x         = r_px;
  assign bus.y         = r_py;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// Module  : tb_sprite_blitter
// Brief   : Randomized and directed bench for sprite_blitter with a pixel-list model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_blitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_acc = -1;
  int   last_done = -1;

  logic [8:0] rom [256];

  typedef struct {
    int due;
    int x;
    int y;
    int col;
  } exp_t;

  exp_t exp_pix[$];
  int   exp_done[$];

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected plot list for a request accepted on edge number a.
  function automatic void model(input int a);
    int  xs, ys, d, col;
    bit  tr;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        xs  = int'(bus.req_x) + c;
        ys  = int'(bus.req_y) + r;
        d   = int'(rom[int'(bus.req_sprite) * 64 + r * 8 + c]);
        col = bus.req_erase ? int'(bus.req_colour) : d;
`ifdef TRANSPARENCY_EN
        tr  = !bus.req_erase && (d == 511);
`else
        tr  = 1'b0;
`endif
        if (xs < 160 && ys < 120 && !tr)
          exp_pix.push_back('{due: a + r * 8 + c + 3, x: xs, y: ys, col: col});
      end
    end
    exp_done.push_back(a + 67);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.req_valid && bus.req_ready) begin
        model(cyc + 1);
        last_acc = cyc;
      end
      if (bus.plot) begin
        if (exp_pix.size() == 0) begin
          check("extra_plot", 1, 0);
        end else begin
          e = exp_pix.pop_front();
          check("plot_cycle", cyc, e.due);
          check("plot_x", int'(bus.x), e.x);
          check("plot_y", int'(bus.y), e.y);
          check("plot_colour", int'(bus.colour), e.col);
        end
      end
      if (bus.done) begin
        last_done = cyc;
        if (exp_done.size() == 0) check("extra_done", 1, 0);
        else check("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready && exp_pix.size() == 0 && exp_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                      input logic e, input logic [8:0] c);
    @(posedge clk);
    #1;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_sprite = s;
    bus.req_erase  = e;
    bus.req_colour = c;
    bus.req_valid  = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_x     = 8'($urandom);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_sprite = '0;
    bus.req_erase  = 1'b0;
    bus.req_colour = '0;
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.req_ready), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_xy", int'({bus.x, bus.y}), 0);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    #1 reset = 1'b0;
    #1 check("ready_before_edge", int'(bus.req_ready), 0);
    @(posedge clk);
    #1 check("ready_after_edge", int'(bus.req_ready), 1);

    // Basic draw from sprite 1 with distinct ROM contents.
    send(8'd10, 7'd20, 2'd1, 1'b0, 9'd0);
    wait_idle();
    check("rom_addr_hold", int'(bus.rom_addr), 127);

    // Bottom-right clipping.
    send(8'd156, 7'd116, 2'd3, 1'b0, 9'd0);
    wait_idle();

    // Erase over an all-key ROM.
    for (int i = 0; i < 256; i++) rom[i] = 9'h1FF;
    send(8'd0, 7'd0, 2'd2, 1'b1, 9'h049);
    wait_idle();

    // Half-transparent sprite 0.
    for (int i = 0; i < 64; i++) rom[i] = (i % 8 < 4) ? 9'h1FF : 9'(i + 5);
    send(8'd40, 7'd40, 2'd0, 1'b0, 9'd0);
    wait_idle();

    // Back-to-back with req_x changed while busy.
    @(posedge clk);
    #1;
    bus.req_x      = 8'd30;
    bus.req_y      = 7'd50;
    bus.req_sprite = 2'd0;
    bus.req_erase  = 1'b0;
    bus.req_valid  = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 bus.req_x = 8'd90;
    wait_ready();
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("b2b_accept", last_acc, last_done + 1);
    wait_idle();

    // Randomized requests over a random ROM with sprinkled colour keys.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 256; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      send(8'($urandom_range(0, 170)), 7'($urandom_range(0, 127)), 2'($urandom),
           1'($urandom), 9'($urandom));
      wait_idle();
    end

    // Reset in the middle of a draw.
    send(8'd5, 7'd5, 2'd1, 1'b0, 9'd0);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_plot", int'(bus.plot), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_ready", int'(bus.req_ready), 0);
    exp_pix.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("midrst_ready_held", int'(bus.req_ready), 0);
    @(posedge clk);
    #1 check("midrst_ready_rise", int'(bus.req_ready), 1);
    repeat (80) @(posedge clk);

    check("left_pixels", exp_pix.size(), 0);
    check("left_done", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
